conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 137 +++++++++++++
 tb/tb_conv_window_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 sliding window.
// Two line buffers plus per-row column shifters, valid windows only.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] win0,
  output logic [31:0] win1,
  output logic [31:0] win2,
  output logic [31:0] win3,
  output logic [31:0] win4,
  output logic [31:0] win5,
  output logic [31:0] win6,
  output logic [31:0] win7,
  output logic [31:0] win8,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [31:0] lb1_q [IMG_W];
  logic [31:0] lb2_q [IMG_W];
  logic [31:0] lb1_rd, lb2_rd;

  // [0] holds column c-2, [1] column c-1; live input is column c
  logic [31:0] top_q [2];
  logic [31:0] mid_q [2];
  logic [31:0] cur_q [2];

  logic [31:0] win_q [9];
  logic [31:0] win_d [9];

  logic mv_q, mv_d;
  logic fd_q, fd_d;
  logic acc, col_end, row_end, produce;

  assign s_ready = !mv_q || m_ready;
  assign acc     = s_valid && s_ready;
  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == RW'(IMG_H - 1);
  assign produce = acc && (row_q >= RW'(2))
                       && (col_q >= CW'(2));
  assign lb1_rd  = lb1_q[col_q];
  assign lb2_rd  = lb2_q[col_q];

  // next-state: raster counters, output handshake, window load
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (produce)      mv_d = 1'b1;
    else if (m_ready) mv_d = 1'b0;
    else              mv_d = mv_q;
    fd_d = acc && col_end && row_end;
    win_d = win_q;
    if (produce) begin
      win_d[0] = top_q[0];
      win_d[1] = top_q[1];
      win_d[2] = lb2_rd;
      win_d[3] = mid_q[0];
      win_d[4] = mid_q[1];
      win_d[5] = lb1_rd;
      win_d[6] = cur_q[0];
      win_d[7] = cur_q[1];
      win_d[8] = s_data;
    end
  end

  // line buffers shift down one row per accepted pixel; no reset needed
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= s_data;
    end
  end

  // control, column shifters and registered window outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      mv_q  <= 1'b0;
      fd_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        cur_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      mv_q  <= mv_d;
      fd_q  <= fd_d;
      if (acc) begin
        top_q[0] <= top_q[1];
        top_q[1] <= lb2_rd;
        mid_q[0] <= mid_q[1];
        mid_q[1] <= lb1_rd;
        cur_q[0] <= cur_q[1];
        cur_q[1] <= s_data;
      end
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  assign win0       = win_q[0];
  assign win1       = win_q[1];
  assign win2       = win_q[2];
  assign win3       = win_q[3];
  assign win4       = win_q[4];
  assign win5       = win_q[5];
  assign win6       = win_q[6];
  assign win7       = win_q[7];
  assign win8       = win_q[8];
  assign m_valid    = mv_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed checks of the 3x3 window generator.
// 4x4 instance for main tests, 5x3 instance for random-valid test.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [31:0] aw [9];
  logic [31:0] bw [9];
  logic        a_mv, b_mv, a_mr, b_mr, a_fd, b_fd;

  int total = 0;
  int bad = 0;
  int fd_a = 0;
  int fd_b = 0;
  logic [31:0] got_a [$];
  logic [31:0] got_b [$];
  logic [31:0] exp_q [$];

  conv_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .win0(aw[0]), .win1(aw[1]), .win2(aw[2]),
    .win3(aw[3]), .win4(aw[4]), .win5(aw[5]),
    .win6(aw[6]), .win7(aw[7]), .win8(aw[8]),
    .m_valid(a_mv), .m_ready(a_mr), .frame_done(a_fd)
  );

  conv_window_gen #(.IMG_W(5), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .win0(bw[0]), .win1(bw[1]), .win2(bw[2]),
    .win3(bw[3]), .win4(bw[4]), .win5(bw[5]),
    .win6(bw[6]), .win7(bw[7]), .win8(bw[8]),
    .m_valid(b_mv), .m_ready(b_mr), .frame_done(b_fd)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // windows are taken on the edge after a negedge with valid&ready
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_mv && a_mr)
        for (int i = 0; i < 9; i++) got_a.push_back(aw[i]);
      if (b_mv && b_mr)
        for (int i = 0; i < 9; i++) got_b.push_back(bw[i]);
      if (a_fd) fd_a++;
      if (b_fd) fd_b++;
    end
  end

  task automatic send_a(input logic [31:0] d);
    int n = 0;
    logic ok = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_a_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [31:0] d);
    int n = 0;
    logic ok = 1'b0;
    b_valid = 1'b1;
    b_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = b_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_b_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame_a(input int base);
    for (int k = 0; k < 16; k++) begin
      send_a(32'(base + k) << 16);
      if (k == 15) check("fd_on_last", 32'(a_fd), 32'd1);
      else if (k == 14) check("fd_not_early", 32'(a_fd), 32'd0);
    end
    a_valid = 1'b0;
  endtask

  task automatic exp_a(input int base);
    for (int r = 2; r < 4; r++)
      for (int c = 2; c < 4; c++)
        for (int i = 0; i < 9; i++)
          exp_q.push_back(32'(base + (r - 2 + i / 3) * 4
                              + c - 2 + i % 3) << 16);
  endtask

  function automatic logic [31:0] pix_b(input int k);
    return 32'hF000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic cmp_a(input string tag);
    check({tag, "_count"}, 32'(got_a.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
      check($sformatf("%s_w%0d_%0d", tag, i / 9, i % 9),
            got_a[i], exp_q[i]);
    got_a.delete();
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic staller();
    int n = 0;
    while (!a_mv && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!a_mv) check("stall_wait_timeout", 32'd0, 32'd1);
    a_mr = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", 32'(a_ready), 32'd0);
      check("stall_mv", 32'(a_mv), 32'd1);
      check("stall_w0", aw[0], 32'd0 << 16);
      check("stall_w4", aw[4], 32'd5 << 16);
      check("stall_w8", aw[8], 32'd10 << 16);
    end
    @(posedge clk);
    #1;
    a_mr = 1'b1;
  endtask

  initial begin
    a_valid = 1'b0; a_data = '0; a_mr = 1'b1;
    b_valid = 1'b0; b_data = '0; b_mr = 1'b1;
    rst_n = 1'b0;
    cycles(2);
    check("rst_mv", 32'(a_mv), 32'd0);
    check("rst_fd", 32'(a_fd), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_w0", aw[0], 32'd0);
    check("rst_w8", aw[8], 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // single frame, free-running downstream
    fd_a = 0;
    exp_a(0);
    frame_a(0);
    cycles(4);
    cmp_a("f1");
    check("f1_fd_count", 32'(fd_a), 32'd1);
    check("f1_mv_idle", 32'(a_mv), 32'd0);

    // downstream stall on first window
    fd_a = 0;
    exp_a(0);
    fork
      frame_a(0);
      staller();
    join
    cycles(4);
    cmp_a("stall");
    check("stall_fd_count", 32'(fd_a), 32'd1);

    // two back-to-back frames
    fd_a = 0;
    exp_a(0);
    exp_a(100);
    frame_a(0);
    frame_a(100);
    cycles(4);
    cmp_a("b2b");
    check("b2b_fd_count", 32'(fd_a), 32'd2);

    // reset mid-frame with a pending window
    a_mr = 1'b0;
    for (int k = 0; k <= 10; k++) send_a(32'(k) << 16);
    a_valid = 1'b0;
    check("pre_rst_mv", 32'(a_mv), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mv", 32'(a_mv), 32'd0);
    check("mid_rst_w4", aw[4], 32'd0);
    check("mid_rst_ready", 32'(a_ready), 32'd1);
    cycles(2);
    rst_n = 1'b1;
    a_mr = 1'b1;
    cycles(1);
    check("mid_rst_nogot", 32'(got_a.size()), 32'd0);
    fd_a = 0;
    exp_a(0);
    frame_a(0);
    cycles(4);
    cmp_a("post_rst");
    check("post_rst_fd", 32'(fd_a), 32'd1);

    // 5x3 with random input gaps
    fd_b = 0;
    got_b.delete();
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 1)) begin
        b_valid = 1'b0;
        b_data  = 32'hDEAD_BEEF;
        cycles(1);
      end
      send_b(pix_b(k));
    end
    b_valid = 1'b0;
    cycles(4);
    check("b_count", 32'(got_b.size()), 32'd27);
    for (int c = 2; c < 5; c++)
      for (int i = 0; i < 9; i++)
        if ((c - 2) * 9 + i < got_b.size())
          check($sformatf("b_w%0d_%0d", c - 2, i),
                got_b[(c - 2) * 9 + i],
                pix_b((i / 3) * 5 + c - 2 + i % 3));
    check("b_fd_count", 32'(fd_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
